hazard_stall_ctrl: RTL
======================

// Module: hazard_stall_ctrl
// PURPOSE
//  Sequences the IF/ID and ID/EX latches around the decode stage: detects load-use RAW hazards and taken branches.
//  Drives PC/IF-ID write enables, an ID/EX bubble (zero control fields) and an IF/ID flush.
//  Multi-cycle stalls and flushes are held by a small FSM with down-counter.
//  Sits beside decode; consumes decoded register fields plus EX/MEM status.
// PARAMETERS
//  STALL_CYCLES  1   bubbles inserted per load-use hazard (legal 1..15)
//  FLUSH_CYCLES  1   bubbles inserted per taken branch (legal 1..15)
//  PERF_W        16  width of performance counters
// PORTS
//  clk                  in   1       rising-edge clock
//  rst                  in   1       synchronous, active-high reset
//  if_id_rs             in   5       rs field of instruction in IF/ID
//  if_id_rt             in   5       rt field of instruction in IF/ID
//  if_id_uses_rt        in   1       1 = instruction reads rt (R-type, beq, sw)
//  id_ex_mem_read       in   1       instruction in ID/EX is a load
//  id_ex_rt             in   5       destination (rt) of that load
//  ex_mem_branch_taken  in   1       branch resolved taken in EX/MEM
//  pc_write             out  1       PC load enable
//  if_id_write          out  1       IF/ID latch enable
//  id_ex_bubble         out  1       force wb/mem/ex control to 0 into ID/EX
//  if_id_flush          out  1       clear IF/ID instruction to NOP
//  ctrl_state           out  2       0 RUN, 1 STALL, 2 FLUSH
//  perf_stall_cnt       out  PERF_W  total stall bubbles (see CONFIGURATION)
//  perf_flush_cnt       out  PERF_W  total flush bubbles
// BEHAVIOUR
//  - hazard = id_ex_mem_read & id_ex_rt!=0 & (id_ex_rt==if_id_rs | (if_id_uses_rt & id_ex_rt==if_id_rt)).
//  - Register 0 never creates a hazard.
//  - Outputs are Mealy: hazard/branch act in the same cycle they are seen (0-cycle latency).
//  - Default (RUN, no event): pc_write=1, if_id_write=1, id_ex_bubble=0, if_id_flush=0.
//  - RUN + branch_taken: pc_write=1, if_id_write=1, id_ex_bubble=1, if_id_flush=1.
//    Load cnt=FLUSH_CYCLES-1; go FLUSH if cnt!=0 else stay RUN.
//  - RUN + hazard (no branch): pc_write=0, if_id_write=0, id_ex_bubble=1, if_id_flush=0.
//    Load cnt=STALL_CYCLES-1; go STALL if cnt!=0 else stay RUN.
//  - Branch has priority over hazard in the same cycle.
//  - STALL: same outputs as hazard cycle; cnt decrements, at cnt==1 next state RUN.
//    Hazard is not re-evaluated inside STALL.
//  - STALL + branch_taken: abort stall, apply flush outputs, reload cnt from FLUSH_CYCLES, enter FLUSH/RUN as above.
//  - FLUSH: pc_write=0, if_id_write=1, id_ex_bubble=1, if_id_flush=1.
//    cnt decrements, at cnt==1 next state RUN. Further branch_taken is ignored (wrong-path).
//  - Reset (rst=1 at edge): state RUN, cnt 0, perf counters 0.
//    While rst is high, outputs are forced safe: pc_write=0, if_id_write=0, id_ex_bubble=1, if_id_flush=1.
//    Reset mid-STALL/FLUSH aborts the sequence with no residual bubbles.
//  - cnt is 4 bits. Illegal ctrl_state value 3 returns to RUN on the next edge with default outputs.
// CONFIGURATION
//  HAZARD_PERF_CNT_EN defined:
//    perf_stall_cnt +1 on every cycle with stall outputs.
//    perf_flush_cnt +1 on every cycle with if_id_flush=1 (excluding reset).
//    Both saturate at all-ones and never wrap.
//  HAZARD_PERF_CNT_EN undefined: both outputs tied 0; no counter flops are inferred.
// TESTING
//  1 lw writes r5 (id_ex_mem_read=1, id_ex_rt=5), if_id_rs=5, STALL_CYCLES=1 -> one cycle pc_write=0, id_ex_bubble=1, state stays RUN.
//  2 Same hazard with STALL_CYCLES=3 -> 3 consecutive stall cycles, ctrl_state 1,1 then 0, then pc_write=1.
//  3 id_ex_rt=0, if_id_rs=0, id_ex_mem_read=1 -> no stall; rt match with if_id_uses_rt=0 -> no stall.
//  4 Hazard and branch_taken in same cycle, FLUSH_CYCLES=2 -> flush outputs (if_id_flush=1, pc_write=1); next cycle FLUSH with pc_write=0; then RUN.
//  5 STALL_CYCLES=4, branch_taken on 2nd stall cycle -> immediate flush outputs; no remaining stall bubbles.
//  6 rst pulsed in mid-STALL -> safe outputs while high, RUN next cycle; with HAZARD_PERF_CNT_EN, counters read 0 then count from 0.

Source files
------------

// File: rtl/hazard_stall_ctrl_if.sv
// Decode-stage hazard interface: register fields and EX/MEM status in, latch controls out.
// Every signal is level-sensitive and sampled each cycle; there is no valid/ready pairing.
interface hazard_stall_ctrl_if #(
   parameter int PERF_W = 16
);
   logic [4:0]        if_id_rs;
   logic [4:0]        if_id_rt;
   logic              if_id_uses_rt;
   logic              id_ex_mem_read;
   logic [4:0]        id_ex_rt;
   logic              ex_mem_branch_taken;
   logic              pc_write;
   logic              if_id_write;
   logic              id_ex_bubble;
   logic              if_id_flush;
   logic [1:0]        ctrl_state;
   logic [PERF_W-1:0] perf_stall_cnt;
   logic [PERF_W-1:0] perf_flush_cnt;

   modport master (
      output if_id_rs, if_id_rt, if_id_uses_rt, id_ex_mem_read, id_ex_rt, ex_mem_branch_taken,
      input  pc_write, if_id_write, id_ex_bubble, if_id_flush, ctrl_state,
      input  perf_stall_cnt, perf_flush_cnt
   );

   modport slave (
      input  if_id_rs, if_id_rt, if_id_uses_rt, id_ex_mem_read, id_ex_rt, ex_mem_branch_taken,
      output pc_write, if_id_write, id_ex_bubble, if_id_flush, ctrl_state,
      output perf_stall_cnt, perf_flush_cnt
   );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// Load-use / taken-branch stall and flush sequencer for the IF/ID and ID/EX latches.
// Optional saturating bubble counters are enabled by defining HAZARD_PERF_CNT_EN.
module hazard_stall_ctrl #(
   parameter int STALL_CYCLES = 1,
   parameter int FLUSH_CYCLES = 1,
   parameter int PERF_W       = 16
) (
   input logic clk,
   input logic rst,
   hazard_stall_ctrl_if.slave hz
);

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_STALL = 2'd1,
      ST_FLUSH = 2'd2,
      ST_BAD   = 2'd3
   } state_t;

   localparam logic [3:0] STALL_LOAD = 4'(STALL_CYCLES - 1);
   localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);

   state_t     state, state_nxt;
   logic [3:0] cnt, cnt_nxt;
   logic       hazard;
   logic       take_flush;
   logic       pc_write, if_id_write, id_ex_bubble, if_id_flush;

   assign hazard = hz.id_ex_mem_read && (hz.id_ex_rt != 5'd0) &&
                   ((hz.id_ex_rt == hz.if_id_rs) ||
                    (hz.if_id_uses_rt && (hz.id_ex_rt == hz.if_id_rt)));

   // A branch only counts from RUN or STALL; inside FLUSH it is on the wrong path.
   assign take_flush = hz.ex_mem_branch_taken && ((state == ST_RUN) || (state == ST_STALL));

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_RUN;
         cnt   <= 4'd0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   always_comb begin
      state_nxt    = state;
      cnt_nxt      = cnt;
      pc_write     = 1'b1;
      if_id_write  = 1'b1;
      id_ex_bubble = 1'b0;
      if_id_flush  = 1'b0;
      if (take_flush) begin
         id_ex_bubble = 1'b1;
         if_id_flush  = 1'b1;
         cnt_nxt      = FLUSH_LOAD;
         state_nxt    = (FLUSH_LOAD != 4'd0) ? ST_FLUSH : ST_RUN;
      end else begin
         case (state)
            ST_RUN: begin
               if (hazard) begin
                  pc_write     = 1'b0;
                  if_id_write  = 1'b0;
                  id_ex_bubble = 1'b1;
                  cnt_nxt      = STALL_LOAD;
                  state_nxt    = (STALL_LOAD != 4'd0) ? ST_STALL : ST_RUN;
               end
            end
            ST_STALL: begin
               pc_write     = 1'b0;
               if_id_write  = 1'b0;
               id_ex_bubble = 1'b1;
               if (cnt <= 4'd1) begin
                  cnt_nxt   = 4'd0;
                  state_nxt = ST_RUN;
               end else begin
                  cnt_nxt = cnt - 4'd1;
               end
            end
            ST_FLUSH: begin
               pc_write     = 1'b0;
               id_ex_bubble = 1'b1;
               if_id_flush  = 1'b1;
               if (cnt <= 4'd1) begin
                  cnt_nxt   = 4'd0;
                  state_nxt = ST_RUN;
               end else begin
                  cnt_nxt = cnt - 4'd1;
               end
            end
            default: begin
               cnt_nxt   = 4'd0;
               state_nxt = ST_RUN;
            end
         endcase
      end
      // Hold the pipeline frozen and flushed while reset is asserted.
      if (rst) begin
         pc_write     = 1'b0;
         if_id_write  = 1'b0;
         id_ex_bubble = 1'b1;
         if_id_flush  = 1'b1;
      end
   end

   assign hz.pc_write     = pc_write;
   assign hz.if_id_write  = if_id_write;
   assign hz.id_ex_bubble = id_ex_bubble;
   assign hz.if_id_flush  = if_id_flush;
   assign hz.ctrl_state   = state;

`ifdef HAZARD_PERF_CNT_EN
   logic [PERF_W-1:0] stall_cnt_q, flush_cnt_q;
   logic              stall_evt, flush_evt;

   assign stall_evt = !rst && !pc_write && !if_id_write && id_ex_bubble && !if_id_flush;
   assign flush_evt = !rst && if_id_flush;

   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         if (stall_evt && (stall_cnt_q != {PERF_W{1'b1}}))
            stall_cnt_q <= stall_cnt_q + 1'b1;
         if (flush_evt && (flush_cnt_q != {PERF_W{1'b1}}))
            flush_cnt_q <= flush_cnt_q + 1'b1;
      end
   end

   assign hz.perf_stall_cnt = stall_cnt_q;
   assign hz.perf_flush_cnt = flush_cnt_q;
`else
   assign hz.perf_stall_cnt = {PERF_W{1'b0}};
   assign hz.perf_flush_cnt = {PERF_W{1'b0}};
`endif

endmodule
